// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: one-vote-per-session arbiter with saturating tallies; `define VOTE_LEADER_EN adds leader/tie outputs.
module vote_session_ctrl #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W = 8,
  parameter int LOCKOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic                          arm,
  input  logic [NUM_CAND-1:0]           valid_vote,
  input  logic                          clear_counts,
  input  logic [$clog2(NUM_CAND)-1:0]   result_sel,
  output logic                          ready_led,
  output logic [NUM_CAND-1:0]           cand_led,
  output logic                          vote_accepted,
  output logic [CNT_W-1:0]              count_out,
  output logic [CNT_W-1:0]              total_out,
  output logic                          sat
`ifdef VOTE_LEADER_EN
  ,
  output logic [$clog2(NUM_CAND)-1:0]   leader,
  output logic                          tie
`endif
);
  localparam int SW = $clog2(NUM_CAND);
  localparam int HW = LOCKOUT > 1 ? $clog2(LOCKOUT) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, RECORD, HOLD} state_t;
  state_t state;
  logic [SW-1:0] idx, pick;
  logic [HW-1:0] hold;
  logic [CNT_W-1:0] total;
  // Sized to a power of two so result_sel never indexes out of range; extra entries stay 0.
  logic [CNT_W-1:0] tally [2**SW];
  always_comb begin
    pick = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) if (valid_vote[i]) pick = SW'(i);
  end
  assign ready_led = state == ARMED;
  assign vote_accepted = state == RECORD;
  assign cand_led = state == HOLD ? NUM_CAND'(1) << idx : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      hold <= '0;
      total <= '0;
      sat <= 1'b0;
      count_out <= '0;
      total_out <= '0;
      for (int i = 0; i < 2**SW; i++) tally[i] <= '0;
    end else begin
      count_out <= mode ? tally[result_sel] : '0;
      total_out <= mode ? total : '0;
      case (state)
        IDLE: begin
          if (arm && !mode) state <= ARMED;
          if (clear_counts && mode) begin
            total <= '0;
            sat <= 1'b0;
            for (int i = 0; i < 2**SW; i++) tally[i] <= '0;
          end
        end
        ARMED: begin
          if (mode) state <= IDLE;
          else if (|valid_vote) begin
            idx <= pick;
            state <= RECORD;
          end
        end
        RECORD: begin
          if (&tally[idx]) sat <= 1'b1;
          else begin
            tally[idx] <= tally[idx] + 1'b1;
            if (&total) sat <= 1'b1;
            else total <= total + 1'b1;
          end
          hold <= HW'(LOCKOUT - 1);
          state <= HOLD;
        end
        HOLD: begin
          if (hold == '0) state <= IDLE;
          else hold <= hold - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef VOTE_LEADER_EN
  logic [SW-1:0] lead_c;
  logic [CNT_W-1:0] max_c;
  logic tie_c;
  always_comb begin
    lead_c = '0;
    max_c = tally[0];
    tie_c = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (tally[i] > max_c) begin
        max_c = tally[i];
        lead_c = SW'(i);
        tie_c = 1'b0;
      end else if (tally[i] == max_c) tie_c = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      leader <= '0;
      tie <= 1'b0;
    end else begin
      leader <= mode ? lead_c : '0;
      tie <= mode && tie_c && max_c != '0;
    end
  end
`endif
endmodule
